// File: rtl/rtl_logic_pkg.sv
// Shared definitions for the two-stage logic pipeline: operator codes and the
// bitwise operator function used by the datapath.
package rtl_logic_pkg;

  localparam int MAX_W = 64;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Operands are zero-extended to MAX_W; callers truncate back to their width.
  function automatic logic [MAX_W-1:0] apply_op(input logic [1:0] op,
                                                input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rtl_logic_op.sv
// Combinational WIDTH-bit operator unit selecting AND/OR/XOR/NAND per beat.
module rtl_logic_op
  import rtl_logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = WIDTH'(apply_op(op, MAX_W'(a), MAX_W'(b)));

endmodule

// File: rtl/rtl_logic_pipe.sv
// Two-stage registered logic pipeline: g = op1(x1, x2), f = op2(g, x3), with
// valid tracking, global stall and a saturating count of non-zero results.
module rtl_logic_pipe
  import rtl_logic_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit ALIGN_X3 = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [1:0]       op1,
  input  logic [1:0]       op2,
  input  logic             count_clr,
  output logic [WIDTH-1:0] g,
  output logic             g_valid,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       op2_q;
  logic [WIDTH-1:0] x3_q;
  logic [WIDTH-1:0] x3_sel;
  logic [WIDTH-1:0] g_next;
  logic [WIDTH-1:0] f_next;
  logic             f_load;

  // Aligned mode uses the x3 captured with the beat; legacy mode uses live x3.
  assign x3_sel = ALIGN_X3 ? x3_q : x3;
  assign f_load = en && g_valid;

  rtl_logic_op #(.WIDTH(WIDTH)) u_stage1 (
    .op (op1),
    .a  (x1),
    .b  (x2),
    .y  (g_next)
  );

  rtl_logic_op #(.WIDTH(WIDTH)) u_stage2 (
    .op (op2_q),
    .a  (g),
    .b  (x3_sel),
    .y  (f_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      g         <= '0;
      g_valid   <= 1'b0;
      f         <= '0;
      f_valid   <= 1'b0;
      op2_q     <= '0;
      x3_q      <= '0;
      hit_count <= '0;
    end else begin
      if (en) begin
        g_valid <= in_valid;
        if (in_valid) begin
          g     <= g_next;
          op2_q <= op2;
          x3_q  <= x3;
        end
        f_valid <= g_valid;
        if (g_valid) begin
          f <= f_next;
        end
      end
      // Clear wins over a same-cycle increment and ignores the stall.
      if (count_clr) begin
        hit_count <= '0;
      end else if (f_load && (f_next != '0) && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rtl_logic_pipe.sv
// Self-checking bench: legacy WIDTH=1 waveform check plus directed and random
// beats on a WIDTH=4 aligned pipeline compared against a beat-level model.
module tb_rtl_logic_pipe;

  localparam bit ALIGN = 1'b1;
  localparam int CMAX  = 3;

  typedef struct {
    logic [3:0] x1;
    logic [3:0] x2;
    logic [3:0] x3;
    logic [1:0] op1;
    logic [1:0] op2;
  } beat_t;

  logic       clock;
  logic       reset, en, in_valid, count_clr;
  logic [3:0] x1, x2, x3;
  logic [1:0] op1, op2;
  logic [3:0] g, f;
  logic       g_valid, f_valid;
  logic [1:0] hit_count;

  logic       lreset;
  logic [0:0] lx1, lx2, lx3, lg, lf;
  logic       lgv, lfv;
  logic [7:0] lcnt;

  int vectors = 0;
  int miscompares = 0;

  beat_t      s_beat;
  logic       m_gv, m_fv;
  logic [3:0] m_g, m_f;
  int         m_cnt;

  rtl_logic_pipe #(.WIDTH(4), .ALIGN_X3(1'b1), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid),
    .x1(x1), .x2(x2), .x3(x3), .op1(op1), .op2(op2), .count_clr(count_clr),
    .g(g), .g_valid(g_valid), .f(f), .f_valid(f_valid), .hit_count(hit_count)
  );

  rtl_logic_pipe #(.WIDTH(1), .ALIGN_X3(1'b0), .CNT_W(8)) dut_legacy (
    .clock(clock), .reset(lreset), .en(1'b1), .in_valid(1'b1),
    .x1(lx1), .x2(lx2), .x3(lx3), .op1(2'b00), .op2(2'b01), .count_clr(1'b0),
    .g(lg), .g_valid(lgv), .f(lf), .f_valid(lfv), .hit_count(lcnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat-level model: a beat in stage 1 yields g from its own operands, and
  // its f is the full two-operator expression evaluated when it leaves.
  task automatic modelStep();
    logic       inc;
    logic [3:0] x3u;
    inc = 1'b0;
    if (reset) begin
      m_gv = 0; m_fv = 0; m_g = 0; m_f = 0; m_cnt = 0;
      s_beat = '{4'd0, 4'd0, 4'd0, 2'd0, 2'd0};
    end else begin
      if (en) begin
        if (m_gv) begin
          x3u = ALIGN ? s_beat.x3 : x3;
          m_f = ref_op(s_beat.op2, ref_op(s_beat.op1, s_beat.x1, s_beat.x2), x3u);
          inc = (m_f != 4'd0);
        end
        m_fv = m_gv;
        m_gv = in_valid;
        if (in_valid) begin
          s_beat = '{x1, x2, x3, op1, op2};
          m_g = ref_op(op1, x1, x2);
        end
      end
      if (count_clr) m_cnt = 0;
      else if (inc && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic checkOutput(input string step);
    checkVal({step, "_g"}, {4'd0, g}, {4'd0, m_g});
    checkVal({step, "_gv"}, {7'd0, g_valid}, {7'd0, m_gv});
    checkVal({step, "_f"}, {4'd0, f}, {4'd0, m_f});
    checkVal({step, "_fv"}, {7'd0, f_valid}, {7'd0, m_fv});
    checkVal({step, "_cnt"}, {6'd0, hit_count}, 8'(m_cnt));
  endtask

  task automatic applyStimulus(input string step, input logic r, input logic e,
                               input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [1:0] o1,
                               input logic [1:0] o2, input logic clr);
    reset = r; en = e; in_valid = v; x1 = a; x2 = b; x3 = c;
    op1 = o1; op2 = o2; count_clr = clr;
    @(posedge clock);
    modelStep();
    #1;
    checkOutput(step);
  endtask

  initial begin
    logic [2:0] lvec [6];
    logic       lprev, eg, ef;
    int         idx, pidx;

    lvec = '{3'b000, 3'b001, 3'b110, 3'b011, 3'b110, 3'b001};
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; count_clr = 1'b0;
    x1 = 0; x2 = 0; x3 = 0; op1 = 0; op2 = 0;
    lreset = 1'b1; lx1 = 0; lx2 = 0; lx3 = 0;
    m_gv = 0; m_fv = 0; m_g = 0; m_f = 0; m_cnt = 0;
    s_beat = '{4'd0, 4'd0, 4'd0, 2'd0, 2'd0};

    // Legacy waveform: inputs change every 15 units, never on a rising edge.
    repeat (2) @(negedge clock);
    lreset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    lprev = 1'b0;
    for (int t = 0; t < 100; t++) begin
      idx = (t / 15 > 5) ? 5 : t / 15;
      {lx1, lx2, lx3} = lvec[idx];
      if (t % 10 == 9) begin
        pidx = ((t - 5) / 15 > 5) ? 5 : (t - 5) / 15;
        eg = lvec[pidx][2] & lvec[pidx][1];
        ef = lprev | lvec[pidx][0];
        checkVal("legacy_g", {7'd0, lg}, {7'd0, eg});
        checkVal("legacy_f", {7'd0, lf}, {7'd0, ef});
        lprev = eg;
      end
      #1;
    end

    $display("[TB] reset state");
    applyStimulus("rst", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst2", 1, 1, 1, 4'hF, 4'hF, 4'hF, 0, 0, 0);

    $display("[TB] aligned operators");
    applyStimulus("al1", 0, 1, 1, 4'b1100, 4'b1010, 4'b0001, 2'b10, 2'b00, 0);
    checkVal("al_g", {4'd0, g}, 8'b0110);
    applyStimulus("al2", 0, 1, 1, 4'b1100, 4'b1010, 4'b0001, 2'b10, 2'b01, 0);
    checkVal("al_f_and", {4'd0, f}, 8'b0000);
    applyStimulus("al3", 0, 1, 0, 4'b0000, 4'b0000, 4'b1000, 0, 0, 0);
    checkVal("al_f_or", {4'd0, f}, 8'b0111);

    $display("[TB] stall");
    applyStimulus("st_b", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("st_b2", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("st_beat", 0, 1, 1, 4'b1111, 4'b0011, 4'b0101, 2'b00, 2'b10, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("st_hold", 0, 0, 1, 4'hA, 4'h5, 4'hF, 2'b01, 2'b11, 0);
      checkVal("st_fv_frozen", {7'd0, f_valid}, 8'd0);
    end
    applyStimulus("st_rel", 0, 1, 0, 0, 0, 4'hF, 0, 0, 0);
    checkVal("st_f", {4'd0, f}, 8'b0110);

    $display("[TB] valid gaps");
    applyStimulus("gap_a", 0, 1, 1, 4'b1010, 4'b0110, 4'b1100, 2'b01, 2'b00, 0);
    applyStimulus("gap_bub", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("gap_b", 0, 1, 1, 4'b0001, 4'b0001, 4'b0001, 2'b00, 2'b00, 0);
    checkVal("gap_f_hold", {4'd0, f}, 8'b1100);
    applyStimulus("gap_end", 0, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] saturating counter");
    applyStimulus("cnt_clr", 0, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("cnt_clr2", 0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("cnt_run", 0, 1, (i < 5), 4'hF, 4'hF, 4'h0, 2'b00, 2'b01, 0);
      checkVal("cnt_seq", {6'd0, hit_count}, 8'((i > 3) ? 3 : i));
    end
    applyStimulus("cnt_beat", 0, 1, 1, 4'hF, 4'hF, 4'h0, 2'b00, 2'b01, 0);
    applyStimulus("cnt_clrinc", 0, 1, 0, 0, 0, 0, 0, 0, 1);
    checkVal("cnt_clr_wins", {6'd0, hit_count}, 8'd0);

    $display("[TB] reset mid-stream");
    applyStimulus("rm1", 0, 1, 1, 4'h7, 4'h9, 4'h3, 2'b01, 2'b10, 0);
    applyStimulus("rm2", 0, 1, 1, 4'hE, 4'h3, 4'h6, 2'b11, 2'b01, 0);
    applyStimulus("rm_rst", 1, 1, 1, 4'hF, 4'hF, 4'hF, 2'b01, 2'b01, 0);
    checkVal("rm_zero", {g, f}, 8'd0);
    applyStimulus("rm_new", 0, 1, 1, 4'b0101, 4'b0011, 4'b0011, 2'b11, 2'b10, 0);
    checkVal("rm_g", {4'd0, g}, 8'b1110);
    applyStimulus("rm_f", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkVal("rm_f", {4'd0, f}, 8'b1101);

    $display("[TB] random beats");
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                    4'($urandom), 2'($urandom), 2'($urandom),
                    ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
